// File: rtl/brlite_tx_arbiter_pkg.sv
// Shared types for the BrLite transmit arbiter: the outgoing flit and the arbiter FSM states.
package brlite_tx_arbiter_pkg;

   typedef struct packed {
      logic [31:0] payload;
      logic [7:0]  src;
      logic [1:0]  service;
   } brlite_out_t;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      RELEASE,
      HOLD
   } brlite_arb_state_t;

endpackage

// File: rtl/brlite_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr (with wrap-around),
// optionally overridden by strict priority for request 0.
module brlite_tx_arbiter_rr_picker #(
   parameter int N_REQ = 2,
   parameter int IDX_W = 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   input  logic             prio0_en,
   output logic             valid,
   output logic [IDX_W-1:0] idx
);

   int j;

   always_comb begin
      // NOTE: every output gets a default first so no path through the block infers a latch.
      valid = 1'b0;
      idx   = '0;
      j     = 0;
      for (int i = 0; i < N_REQ; i++) begin
         j = int'(ptr) + i;
         if (j >= N_REQ) j = j - N_REQ;
         if (!valid && req[j]) begin
            valid = 1'b1;
            idx   = IDX_W'(j);
         end
      end
      if (prio0_en && req[0]) begin
         valid = 1'b1;
         idx   = '0;
      end
   end

endmodule

// File: rtl/brlite_tx_arbiter.sv
// Round-robin arbiter sharing the BrLite local output among N_REQ sources.
// Define BRLITE_ARB_PRIO0_EN to give requester 0 strict priority over the round-robin.
module brlite_tx_arbiter
   import brlite_tx_arbiter_pkg::*;
#(
   parameter  int N_REQ       = 2,
   parameter  int HOLD_CYCLES = 0,
   localparam int IDX_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [N_REQ-1:0]        req_i,
   input  brlite_out_t [N_REQ-1:0] data_i,
   output logic [N_REQ-1:0]        ack_o,
   input  logic                    br_local_busy_i,
   output logic                    br_req_o,
   input  logic                    br_ack_i,
   output brlite_out_t             br_data_o,
   output logic [IDX_W-1:0]        grant_idx_o,
   output logic                    busy_o
);

`ifdef BRLITE_ARB_PRIO0_EN
   localparam bit PRIO0 = 1'b1;
`else
   localparam bit PRIO0 = 1'b0;
`endif

   localparam int                HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

   brlite_arb_state_t state;
   logic [IDX_W-1:0]  rr_ptr;
   logic [HOLD_W-1:0] hold_cnt;
   logic              pick_valid;
   logic [IDX_W-1:0]  pick_idx;

   brlite_tx_arbiter_rr_picker #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_picker (
      .req      (req_i),
      .ptr      (rr_ptr),
      .prio0_en (PRIO0),
      .valid    (pick_valid),
      .idx      (pick_idx)
   );

   assign busy_o = (state != IDLE);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= IDLE;
         br_req_o    <= 1'b0;
         ack_o       <= '0;
         br_data_o   <= '0;
         grant_idx_o <= '0;
         rr_ptr      <= '0;
         hold_cnt    <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         ack_o <= '0;
         case (state)
            IDLE: begin
               if (pick_valid && !br_local_busy_i) begin
                  br_data_o   <= data_i[pick_idx];
                  grant_idx_o <= pick_idx;
                  br_req_o    <= 1'b1;
                  state       <= REQ;
               end
            end
            REQ: begin
               // A requester withdrawing here is ignored; the router already sees the flit.
               if (br_ack_i) begin
                  br_req_o <= 1'b0;
                  ack_o    <= N_REQ'(1) << grant_idx_o;
                  if (!(PRIO0 && grant_idx_o == '0))
                     rr_ptr <= (grant_idx_o == IDX_W'(N_REQ - 1)) ? '0 : grant_idx_o + IDX_W'(1);
                  state    <= RELEASE;
               end
            end
            RELEASE: begin
               hold_cnt <= '0;
               state    <= (HOLD_CYCLES > 0) ? HOLD : IDLE;
            end
            HOLD: begin
               if (hold_cnt == HOLD_LAST) state <= IDLE;
               else                       hold_cnt <= hold_cnt + HOLD_W'(1);
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
